// File: rtl/evm_pkg.sv
// Shared types, constants and BCD helpers for the ballot controller and its tally counters.
package evm_pkg;

    localparam int unsigned DIGIT_W         = 4;
    localparam int unsigned TALLY_DIGITS    = 3;
    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_CAST1 = 3'd2,
        S_CAST2 = 3'd3,
        S_DONE1 = 3'd4,
        S_DONE2 = 3'd5,
        S_INV   = 3'd6
    } state_e;

    // Digit 0 is units, digit TALLY_DIGITS-1 is hundreds.
    typedef logic [TALLY_DIGITS-1:0][DIGIT_W-1:0] tally_t;

    typedef struct packed {
        logic admin;
        logic c1;
        logic c2;
    } btn_t;

    function automatic logic tally_full(tally_t t);
        logic full;
        full = 1'b1;
        for (int unsigned i = 0; i < TALLY_DIGITS; i++) begin
            full = full & (t[i] == BCD_MAX_DIGIT);
        end
        return full;
    endfunction

    // Decimal ripple increment; caller guarantees the tally is not already full.
    function automatic tally_t bcd_inc(tally_t t);
        tally_t r;
        logic   carry;
        r     = t;
        carry = 1'b1;
        for (int unsigned i = 0; i < TALLY_DIGITS; i++) begin
            if (carry) begin
                if (r[i] == BCD_MAX_DIGIT) begin
                    r[i] = '0;
                end else begin
                    r[i]  = r[i] + DIGIT_W'(1);
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/evm_ballot_ctrl_if.sv
// Panel-side bundle: admin/candidate/clear inputs and LED/tally outputs of the ballot controller.
interface evm_ballot_ctrl_if;
    import evm_pkg::*;

    logic               admin;
    logic               c1;
    logic               c2;
    logic               clear_tally;
    logic               led;
    logic               led1;
    logic               led2;
    logic               invalid;
    logic [DIGIT_W-1:0] x1;
    logic [DIGIT_W-1:0] y1;
    logic [DIGIT_W-1:0] z1;
    logic [DIGIT_W-1:0] x2;
    logic [DIGIT_W-1:0] y2;
    logic [DIGIT_W-1:0] z2;

    modport master (
        output admin, c1, c2, clear_tally,
        input  led, led1, led2, invalid, x1, y1, z1, x2, y2, z2
    );

    modport slave (
        input  admin, c1, c2, clear_tally,
        output led, led1, led2, invalid, x1, y1, z1, x2, y2, z2
    );

endinterface

// File: rtl/evm_bcd3_counter.sv
// Three-digit BCD tally with synchronous clear and saturation at 999.
module evm_bcd3_counter
    import evm_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] hundreds,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] units
);

    tally_t tally_q;
    tally_t tally_d;

    always_comb begin
        tally_d = tally_q;
        if (clr) begin
            tally_d = '0;
        end else if (inc && !tally_full(tally_q)) begin
            tally_d = bcd_inc(tally_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tally_q <= '0;
        end else begin
            tally_q <= tally_d;
        end
    end

    assign hundreds = tally_q[2];
    assign tens     = tally_q[1];
    assign units    = tally_q[0];

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Ballot sequencing controller: arming, one-vote acceptance, reject policy and tally increments.
// Optional arming timeout is built only when EVM_TIMEOUT_EN is defined.
module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    evm_ballot_ctrl_if.slave  bus
);

    btn_t   btn_q;
    btn_t   btn_p;
    btn_t   edge_q;
    state_e state_q;
    state_e state_d;
    logic   load_tmr_c;
    logic   timeout_c;
    logic   led_q;
    logic   led1_q;
    logic   led2_q;
    logic   invalid_q;
    logic   inc1_c;
    logic   inc2_c;

    // Edge pulse is registered so the FSM acts two edges after the button is sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q  <= '0;
            btn_p  <= '0;
            edge_q <= '0;
        end else begin
            btn_q  <= {bus.admin, bus.c1, bus.c2};
            btn_p  <= btn_q;
            edge_q <= btn_q & ~btn_p;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_tmr_c = 1'b0;
        if (bus.clear_tally) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (edge_q.c1 || edge_q.c2) begin
                        state_d = S_INV;
                    end else if (edge_q.admin) begin
                        state_d    = S_ARMED;
                        load_tmr_c = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (edge_q.c1 && edge_q.c2) begin
                        state_d = S_INV;
                    end else if (edge_q.c1) begin
                        state_d = S_CAST1;
                    end else if (edge_q.c2) begin
                        state_d = S_CAST2;
                    end else if (edge_q.admin) begin
                        load_tmr_c = 1'b1;
                    end else if (timeout_c) begin
                        state_d = S_INV;
                    end
                end
                S_CAST1: state_d = S_DONE1;
                S_CAST2: state_d = S_DONE2;
                S_DONE1, S_DONE2, S_INV: begin
                    if (edge_q.admin) begin
                        state_d    = S_ARMED;
                        load_tmr_c = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            led_q     <= 1'b0;
            led1_q    <= 1'b0;
            led2_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= (state_d == S_ARMED);
            led1_q    <= (state_d inside {S_CAST1, S_DONE1});
            led2_q    <= (state_d inside {S_CAST2, S_DONE2});
            invalid_q <= (state_d == S_INV);
        end
    end

`ifdef EVM_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMR_W-1:0] tmr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q <= '0;
        end else if (load_tmr_c) begin
            tmr_q <= TMR_W'(TIMEOUT - 1);
        end else if ((state_q == S_ARMED) && (tmr_q != '0)) begin
            tmr_q <= tmr_q - TMR_W'(1);
        end
    end

    assign timeout_c = (state_q == S_ARMED) && (tmr_q == '0);
`else
    logic unused_tmr_c;

    assign timeout_c    = 1'b0;
    assign unused_tmr_c = load_tmr_c ^ (^32'(TIMEOUT));
`endif

    assign inc1_c = (state_q == S_CAST1);
    assign inc2_c = (state_q == S_CAST2);

    evm_bcd3_counter u_tally1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (bus.clear_tally),
        .inc      (inc1_c),
        .hundreds (bus.x1),
        .tens     (bus.y1),
        .units    (bus.z1)
    );

    evm_bcd3_counter u_tally2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (bus.clear_tally),
        .inc      (inc2_c),
        .hundreds (bus.x2),
        .tens     (bus.y2),
        .units    (bus.z2)
    );

    assign bus.led     = led_q;
    assign bus.led1    = led1_q;
    assign bus.led2    = led2_q;
    assign bus.invalid = invalid_q;

endmodule

// File: doc/evm_ballot_ctrl.md
# evm_ballot_ctrl

Sequencing controller for the electronic voting machine: it arms the ballot on an admin request, accepts exactly one candidate press per arming, and rejects simultaneous or unarmed presses as invalid. It also drives increment commands into two 3-digit BCD tally counters. It sits between the raw panel inputs (admin, candidate buttons) and the tally/LED display, and owns all vote-acceptance policy.

## Interface
- `TIMEOUT`, default 16: cycles an armed ballot waits for a press before being voided; only used with `EVM_TIMEOUT_EN`.
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `admin` in 1: arm request; rising edge is significant.
- `c1` in 1: candidate 1 button; rising edge is significant.
- `c2` in 1: candidate 2 button; rising edge is significant.
- `clear_tally` in 1: synchronous clear of all tallies and flags; level.
- `led` out 1: ballot armed (state ARMED).
- `led1` out 1: vote for candidate 1 accepted (CAST1, DONE1).
- `led2` out 1: vote for candidate 2 accepted (CAST2, DONE2).
- `invalid` out 1: sticky reject flag.
- `x1`, `y1`, `z1` out 4 each: candidate 1 tally, BCD hundreds, tens and units.
- `x2`, `y2`, `z2` out 4 each: candidate 2 tally, BCD hundreds, tens and units.

## Operation
- All outputs are 0 at reset. The state is IDLE and both tallies are 000.
- Inputs are registered once (`*_q`), with a second stage (`*_p`). The edge is `*_q & ~*_p`.
- States are IDLE, ARMED, CAST1, CAST2, DONE1, DONE2 and INV.
- **IDLE**
  - admin edge goes to ARMED.
  - Any c1/c2 edge goes to INV. No count.
- **ARMED**
  - c1 edge alone goes to CAST1.
  - c2 edge alone goes to CAST2.
  - c1 and c2 edges in the same cycle go to INV.
  - A candidate edge takes priority over a coincident admin edge.
  - An admin edge alone restarts the timeout and stays in ARMED.
- **CAST1/CAST2** last one cycle. They pulse `inc1`/`inc2` into the tally and then go to DONE1/DONE2.
- **DONE1/DONE2/INV**
  - Candidate edges are ignored (lockout). They do not count and do not raise `invalid`.
  - admin edge goes to ARMED and clears `led1`, `led2` and `invalid`.
- `invalid` is 1 exactly in state INV.
- Tally arithmetic:
  - BCD increment with decimal carry: units 9 to 0 carries into tens; tens 9 to 0 carries into hundreds.
  - Saturates at 999: an increment at 999 leaves 999 unchanged. The vote is still shown as accepted (`led1`/`led2`).
  - Digits never hold values 10–15.
- `clear_tally` has priority over everything else. On the next edge it zeroes both tallies, goes to IDLE and deasserts all LEDs and `invalid`.

## Timing
- A button high at sampling edge k is registered as the edge in the cycle after k. The state changes at edge k+2.
- CAST state is entered at edge k+2; the tally digit updates at edge k+3. `led1`/`led2` are high from edge k+2 onward.
- From admin edge sampled at k, `led` rises at edge k+2.
- A button held high produces one edge only. It must return low before it can count again.
- `reset_n` asserted mid-CAST aborts the increment. The tally is cleared like every other register.
- Timeout:
  - The counter loads `TIMEOUT-1` on entry to ARMED, and reloads on an admin edge in ARMED.
  - It decrements each cycle. When it reaches 0 with no press, the state goes to INV on the next edge.
  - A press in the same cycle the counter hits 0 wins.

## Configuration
- Macro `EVM_TIMEOUT_EN`.
  - Defined: the timeout counter is present and an unused arming expires to INV after `TIMEOUT` cycles.
  - Undefined: the counter is not built, `TIMEOUT` is ignored, and ARMED waits indefinitely.

## Structure
- Package `evm_pkg`:
  - state encoding (7 states, 3 bits).
  - `BCD_MAX_DIGIT = 4'd9`.
  - `TALLY_DIGITS = 3`.
  - default `TIMEOUT`.
- Sub-module `evm_bcd3_counter` (`clk`, `reset_n`, `clr`, `inc`, `hundreds`/`tens`/`units`, saturating at 999). It is instantiated twice.
- The FSM, edge detectors and timeout counter live in `evm_ballot_ctrl`.

## Test plan
- Reset, admin pulse, then c1 pulse: `led` rises, then `led1`=1 and `z1` goes 0 to 1. A second c1 before the next admin leaves `z1`=1 and `invalid`=0.
- Admin, then c1 and c2 rising in the same cycle: `invalid`=1 and tallies unchanged. Admin again: `invalid`=0 and `led`=1.
- c2 with no admin: `invalid`=1 and `z2`=0.
- Preload 99 into candidate 2 via 99 arm/vote cycles, then one more vote: `x2/y2/z2`=1/0/0. Driven to 999, a further vote keeps 9/9/9 with `led2`=1.
- With `EVM_TIMEOUT_EN` and `TIMEOUT`=16: admin then no press gives `invalid`=1 exactly 16 cycles after ARMED entry. Without the macro, `led` stays 1 for 100 cycles.
- Assert `clear_tally` during DONE1, and separately `reset_n`=0 during CAST1: all tallies read 000 and `led`/`led1`/`led2`/`invalid`=0.
